// File: rtl/sand_pkg.sv
// Shared types and constants for the sand physics sweep logic.
// Cell encoding, word geometry and the sweep sequencer state set.
package sand_pkg;

  typedef logic [1:0] cell_t;

  localparam cell_t AIR     = 2'd0;
  localparam cell_t SAND    = 2'd1;
  localparam cell_t SAND_AM = 2'd2;
  localparam cell_t WALL    = 2'd3;

  localparam int CELLS_PER_WORD = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_R,
    RD_F,
    CAP,
    WR_R,
    WR_F
  } sweep_state_t;

endpackage

// File: rtl/sand_addr_gen.sv
// Row/word counters, framebuffer address generation and edge flags.
// Ports: load/adv step the counters; addr_*_nxt give next-cycle addresses;
// last/at_* report counter position. Macro SAND_SPOUT_EN adds the spout match.
module sand_addr_gen
  import sand_pkg::*;
#(
  parameter int WIDTH_WORDS = 20,
  parameter int HEIGHT      = 120,
  parameter int ADDR_W      = 12,
  parameter int SPOUT_WORD  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              adv,
  output logic [ADDR_W-1:0] addr_r_nxt,
  output logic [ADDR_W-1:0] addr_f_nxt,
  output logic              last,
  output logic              at_begin,
  output logic              at_end,
  output logic              at_bottom,
  output logic              at_spout
);

  localparam int RW = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
  localparam int WW = (WIDTH_WORDS > 1) ? $clog2(WIDTH_WORDS) : 1;
  localparam logic [RW-1:0] ROW_TOP  = RW'(HEIGHT - 2);
  localparam logic [WW-1:0] WORD_END = WW'(WIDTH_WORDS - 1);

  if (SPOUT_WORD < 0 || SPOUT_WORD >= WIDTH_WORDS) begin : g_bad_spout
    $error("SPOUT_WORD out of range");
  end

  logic [RW-1:0] row_q, row_d;
  logic [WW-1:0] word_q, word_d;

  // After the final pair the counters reload instead of wrapping.
  always_comb begin
    row_d  = row_q;
    word_d = word_q;
    if (load) begin
      row_d  = ROW_TOP;
      word_d = '0;
    end else if (adv) begin
      if (word_q == WORD_END) begin
        word_d = '0;
        row_d  = (row_q == '0) ? ROW_TOP : row_q - 1'b1;
      end else begin
        word_d = word_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q  <= ROW_TOP;
      word_q <= '0;
    end else begin
      row_q  <= row_d;
      word_q <= word_d;
    end
  end

  // Addresses follow the next counter values so the
  // controller can register them alongside its state.
  assign addr_r_nxt = ADDR_W'(row_d) * ADDR_W'(WIDTH_WORDS)
                    + ADDR_W'(word_d);
  assign addr_f_nxt = addr_r_nxt + ADDR_W'(WIDTH_WORDS);

  assign last      = (row_q == '0) && (word_q == WORD_END);
  assign at_begin  = (word_q == '0);
  assign at_end    = (word_q == WORD_END);
  assign at_bottom = (row_q == ROW_TOP);

`ifdef SAND_SPOUT_EN
  assign at_spout = (row_q == '0) && (word_q == WW'(SPOUT_WORD));
`else
  assign at_spout = 1'b0;
`endif

endmodule

// File: rtl/sand_sweep_ctrl.sv
// Frame sweep sequencer: read region/floor pair, feed datapath, write back.
// Ports: frame_start/busy/done/overrun control, mem_* RAM port, dp_* datapath.
// Macro SAND_SPOUT_EN enables the spout flag at row 0, word SPOUT_WORD.
module sand_sweep_ctrl
  import sand_pkg::*;
#(
  parameter int WIDTH_WORDS = 20,
  parameter int HEIGHT      = 120,
  parameter int ADDR_W      = 12,
  parameter int SPOUT_WORD  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       dp_region,
  output logic [31:0]       dp_floor,
  output logic              dp_screenbegin,
  output logic              dp_screenend,
  output logic              dp_screenbottom,
  output logic              dp_spout,
  input  logic [31:0]       dp_new_region,
  input  logic [31:0]       dp_new_floor
);

  if (HEIGHT < 2) begin : g_bad_height
    $error("HEIGHT must be at least 2");
  end
  if ((2 ** ADDR_W) < WIDTH_WORDS * HEIGHT) begin : g_bad_addr
    $error("ADDR_W too narrow for framebuffer");
  end

  sweep_state_t      state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       reg_q, reg_d;
  logic [31:0]       flr_q, flr_d;
  logic              capr_q, capr_d;

  logic              load, adv, last, win;
  logic              at_begin, at_end, at_bottom, at_spout;
  logic [ADDR_W-1:0] addr_r_nxt, addr_f_nxt;
  logic              granted;

  sand_addr_gen #(
    .WIDTH_WORDS(WIDTH_WORDS),
    .HEIGHT     (HEIGHT),
    .ADDR_W     (ADDR_W),
    .SPOUT_WORD (SPOUT_WORD)
  ) u_addr (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .adv       (adv),
    .addr_r_nxt(addr_r_nxt),
    .addr_f_nxt(addr_f_nxt),
    .last      (last),
    .at_begin  (at_begin),
    .at_end    (at_end),
    .at_bottom (at_bottom),
    .at_spout  (at_spout)
  );

  assign granted = req_q & mem_gnt;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    adv     = 1'b0;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    capr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // done_q marks the first idle cycle; a start
        // there collides with the finishing sweep.
        if (frame_start) begin
          if (done_q) begin
            ovr_d = 1'b1;
          end else begin
            state_d = RD_R;
            load    = 1'b1;
          end
        end
      end
      RD_R: if (granted) begin
        state_d = RD_F;
        capr_d  = 1'b1;
      end
      RD_F: if (granted) state_d = CAP;
      CAP:  state_d = WR_R;
      WR_R: if (granted) state_d = WR_F;
      WR_F: if (granted) begin
        adv = 1'b1;
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = RD_R;
        end
      end
      default: state_d = IDLE;
    endcase
    if (frame_start && busy_q) ovr_d = 1'b1;

    busy_d = (state_d != IDLE);
    req_d  = state_d inside {RD_R, RD_F, WR_R, WR_F};
    we_d   = state_d inside {WR_R, WR_F};
    addr_d = '0;
    if (state_d inside {RD_R, WR_R}) addr_d = addr_r_nxt;
    if (state_d inside {RD_F, WR_F}) addr_d = addr_f_nxt;

    // Read data arrives the cycle after the grant.
    reg_d = capr_q ? mem_rdata : reg_q;
    flr_d = (state_q == CAP) ? mem_rdata : flr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      reg_q   <= '0;
      flr_q   <= '0;
      capr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      reg_q   <= reg_d;
      flr_q   <= flr_d;
      capr_q  <= capr_d;
    end
  end

  // Datapath results settle only after the floor capture,
  // so write data is taken straight from them.
  always_comb begin
    mem_wdata = '0;
    if (state_q == WR_R) mem_wdata = dp_new_region;
    if (state_q == WR_F) mem_wdata = dp_new_floor;
  end

  assign win = state_q inside {CAP, WR_R, WR_F};

  assign busy            = busy_q;
  assign done            = done_q;
  assign overrun         = ovr_q;
  assign mem_req         = req_q;
  assign mem_we          = we_q;
  assign mem_addr        = addr_q;
  assign dp_region       = reg_q;
  assign dp_floor        = flr_q;
  assign dp_screenbegin  = win & at_begin;
  assign dp_screenend    = win & at_end;
  assign dp_screenbottom = win & at_bottom;
  assign dp_spout        = win & at_spout;

endmodule

// File: tb/tb_sand_sweep_ctrl.sv
// Randomised bench for sand_sweep_ctrl against a frame-level model.
// Build with +define+SAND_SPOUT_EN to also exercise the spout flag.
module tb_sand_sweep_ctrl;

  localparam int W  = 2;
  localparam int H  = 4;
  localparam int AW = 12;
  localparam int SP = 1;
  localparam int N  = W * H;
  localparam int PAIRS = (H - 1) * W;

  logic          clk = 1'b0;
  logic          reset, frame_start, mem_gnt;
  logic          busy, done, overrun, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata, dp_region, dp_floor;
  logic          sbeg, send, sbot, spout;
  logic [31:0]   dp_new_region, dp_new_floor;

  assign dp_new_region = ~dp_region;
  assign dp_new_floor  = ~dp_floor;

  sand_sweep_ctrl #(
    .WIDTH_WORDS(W), .HEIGHT(H), .ADDR_W(AW), .SPOUT_WORD(SP)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .busy(busy), .done(done), .overrun(overrun),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dp_region(dp_region),
    .dp_floor(dp_floor), .dp_screenbegin(sbeg),
    .dp_screenend(send), .dp_screenbottom(sbot),
    .dp_spout(spout), .dp_new_region(dp_new_region),
    .dp_new_floor(dp_new_floor)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Framebuffer RAM with one-cycle read latency.
  logic [31:0] ram [N];
  always @(posedge clk) begin
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        if (mem_addr < AW'(N)) ram[mem_addr] = mem_wdata;
      end else begin
        mem_rdata <= (mem_addr < AW'(N)) ? ram[mem_addr] : 32'hdead_beef;
      end
    end
  end

  // Frame-level model: list of expected accesses and final image.
  typedef struct {
    logic        we;
    int          addr;
    logic [31:0] data;
    int          row;
    int          word;
  } acc_t;

  acc_t        expq [$];
  logic [31:0] model [N];

  task automatic preload(input bit rnd);
    for (int i = 0; i < N; i++) begin
      ram[i]   = rnd ? $urandom : 32'(i);
      model[i] = ram[i];
    end
  endtask

  function automatic void build_exp();
    int a, b;
    logic [31:0] nr, nf;
    expq.delete();
    for (int r = H - 2; r >= 0; r--) begin
      for (int w = 0; w < W; w++) begin
        a  = r * W + w;
        b  = a + W;
        nr = ~model[a];
        nf = ~model[b];
        expq.push_back('{1'b0, a, 32'd0, r, w});
        expq.push_back('{1'b0, b, 32'd0, r, w});
        expq.push_back('{1'b1, a, nr, r, w});
        expq.push_back('{1'b1, b, nf, r, w});
        model[a] = nr;
        model[b] = nf;
      end
    end
  endfunction

  // Grant driver: 0 = always, 1 = random, 2 = one 3-cycle stall on write to 2.
  int gmode = 0;
  int st_left = 0;
  bit st_done = 1'b0;
  initial mem_gnt = 1'b1;
  always @(posedge clk) begin
    #1;
    if (gmode == 1) begin
      mem_gnt = ($urandom_range(0, 3) != 0);
    end else if (gmode == 2) begin
      if (st_left > 0) begin
        mem_gnt = 1'b0;
        st_left--;
      end else if (!st_done && mem_req && mem_we && mem_addr == 2) begin
        mem_gnt = 1'b0;
        st_left = 2;
        st_done = 1'b1;
      end else begin
        mem_gnt = 1'b1;
      end
    end else begin
      mem_gnt = 1'b1;
    end
  end

  // Access monitor and stall-stability checker.
  int          stalls = 0;
  bit          hold = 1'b0;
  logic [AW-1:0] h_addr;
  logic [31:0] h_wdata;
  logic        h_we;
  acc_t        e;
  logic        exp_sp;

  always @(negedge clk) begin
    if (hold && !reset) begin
      chk("hold_req", 32'(mem_req), 32'd1);
      chk("hold_addr", 32'(mem_addr), 32'(h_addr));
      chk("hold_we", 32'(mem_we), 32'(h_we));
      chk("hold_wdata", mem_wdata, h_wdata);
    end
    hold = 1'b0;
    if (!reset && mem_req) begin
      if (!mem_gnt) begin
        hold    = 1'b1;
        h_addr  = mem_addr;
        h_we    = mem_we;
        h_wdata = mem_wdata;
        stalls++;
      end else if (expq.size() == 0) begin
        chk("extra_acc", 32'(mem_addr), 32'hffff_ffff);
      end else begin
        e = expq.pop_front();
        chk("acc_addr", 32'(mem_addr), 32'(e.addr));
        chk("acc_we", 32'(mem_we), 32'(e.we));
        if (e.we) begin
`ifdef SAND_SPOUT_EN
          exp_sp = (e.row == 0) && (e.word == SP);
`else
          exp_sp = 1'b0;
`endif
          chk("wdata", mem_wdata, e.data);
          chk("sbegin", 32'(sbeg), 32'(e.word == 0));
          chk("send", 32'(send), 32'(e.word == W - 1));
          chk("sbottom", 32'(sbot), 32'(e.row + 1 == H - 1));
          chk("spout", 32'(spout), 32'(exp_sp));
        end
      end
    end
  end

  task automatic run_sweep(input int gm, input bit ov,
                           output int lat);
    int t0;
    gmode  = gm;
    stalls = 0;
    build_exp();
    @(negedge clk);
    frame_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    frame_start = 1'b0;
    lat = -1;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin
        lat = cyc - t0;
        if (ov) frame_start = 1'b1;
        break;
      end
      if (ov && i == 7) frame_start = 1'b1;
      if (ov && i == 8) frame_start = 1'b0;
      @(negedge clk);
    end
    if (lat < 0) chk("done_timeout", 32'(lat), 32'd0);
    @(negedge clk);
    frame_start = 1'b0;
    chk("post_busy", 32'(busy), 32'd0);
    chk("left_acc", 32'(expq.size()), 32'd0);
    for (int i = 0; i < N; i++) chk("ram", ram[i], model[i]);
  endtask

  int lat;
  logic acc;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    preload(1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle: nothing may move without frame_start.
    acc = 1'b0;
    repeat (20) begin
      @(negedge clk);
      acc = acc | busy | done | mem_req | mem_we | overrun
          | sbeg | send | sbot | spout
          | (|mem_addr) | (|mem_wdata) | (|dp_region) | (|dp_floor);
    end
    chk("idle_quiet", 32'(acc), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Full sweep, grant always high.
    run_sweep(0, 1'b0, lat);
    chk("lat_full", 32'(lat), 32'd31);

    // One three-cycle stall on the first write to address 2.
    st_done = 1'b0;
    run_sweep(2, 1'b0, lat);
    chk("lat_stall", 32'(lat), 32'd34);
    chk("stall_cnt", 32'(stalls), 32'd3);

    // Random data and random grants.
    for (int k = 0; k < 4; k++) begin
      preload(1'b1);
      run_sweep(1, 1'b0, lat);
      chk("lat_rand", 32'(lat), 32'(5 * PAIRS + 1 + stalls));
    end

    // Overrun: start mid-sweep and on the done cycle.
    chk("ovr_before", 32'(overrun), 32'd0);
    preload(1'b1);
    run_sweep(0, 1'b1, lat);
    chk("lat_ovr", 32'(lat), 32'd31);
    chk("ovr_set", 32'(overrun), 32'd1);
    repeat (5) @(negedge clk);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    chk("ovr_nostart", 32'(busy), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ovr_clear", 32'(overrun), 32'd0);

    // Reset during RD_F of the third pair.
    gmode = 0;
    preload(1'b0);
    build_exp();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (11) @(negedge clk);
    chk("abort_addr", 32'(mem_addr), 32'd4);
    chk("abort_we", 32'(mem_we), 32'd0);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_req", 32'(mem_req), 32'd0);
    chk("abort_left", 32'(expq.size()), 32'(4 * PAIRS - 10));
    expq.delete();
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_idle", 32'(busy | mem_req | done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
